// File: rtl/mux_tree_ccff_pipe.sv
// Configurable N_IN:1 routing mux whose select is loaded through a serial config-chain shadow
// register and committed atomically. Define MUX_OUT_REG_EN to register the routed output.
module mux_tree_ccff_pipe #(
    parameter int unsigned N_IN  = 46,
    parameter int unsigned SEL_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  in,
    input  logic             cfg_en,
    input  logic             ccff_head,
    output logic             ccff_tail,
    input  logic             cfg_commit,
    output logic             cfg_done,
    output logic [SEL_W-1:0] sram,
    output logic [SEL_W-1:0] sram_inv,
    output logic             out
);
    localparam int unsigned      CNT_W    = $clog2(SEL_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SEL_W);

    if (SEL_W != $clog2(N_IN)) begin : g_bad_sel_w
        $error("SEL_W must equal ceil(log2(N_IN))");
    end

    logic [SEL_W-1:0] sh_q, sh_d;
    logic [SEL_W-1:0] sram_q, sram_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_idx;
    logic             mux_val;

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        sram_d = sram_q;
        if (cfg_en) begin
            sh_d[0] = ccff_head;
            for (int i = 1; i < SEL_W; i++) begin
                sh_d[i] = sh_q[i-1];
            end
        end
        // A commit captures the pre-shift shadow; a shift in the same cycle counts as bit 1.
        if (cfg_commit && cfg_done) begin
            sram_d = sh_q;
            cnt_d  = cfg_en ? CNT_W'(1) : '0;
        end else if (cfg_en && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            sram_q <= '0;
            cnt_q  <= '0;
        end else begin
            sh_q   <= sh_d;
            sram_q <= sram_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ccff_tail = sh_q[SEL_W-1];
    assign cfg_done  = (cnt_q == CNT_FULL);
    assign sram      = sram_q;
    assign sram_inv  = ~sram_q;

    // Index counts down from the all-ones code; codes past the last input route constant 1.
    always_comb begin
        sel_idx = ~sram_q;
        mux_val = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (sel_idx == SEL_W'(i)) begin
                mux_val = in[i];
            end
        end
    end

`ifdef MUX_OUT_REG_EN
    logic out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= 1'b1;
        end else begin
            out_q <= mux_val;
        end
    end

    assign out = out_q;
`else
    assign out = mux_val;
`endif

endmodule

// File: tb/tb_mux_tree_ccff_pipe.sv
// Self-checking bench for mux_tree_ccff_pipe: constant vector table, directed corner sequences,
// and randomized traffic against an integer-level reference model.
module tb_mux_tree_ccff_pipe;
    localparam int N_IN  = 46;
    localparam int SEL_W = 6;
    localparam int MAXV  = 63;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_IN-1:0] in_w;
    logic            cfg_en, ccff_head, cfg_commit;
    logic            ccff_tail, cfg_done, out;
    logic [SEL_W-1:0] sram, sram_inv;

    mux_tree_ccff_pipe #(.N_IN(N_IN), .SEL_W(SEL_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_w),
        .cfg_en     (cfg_en),
        .ccff_head  (ccff_head),
        .ccff_tail  (ccff_tail),
        .cfg_commit (cfg_commit),
        .cfg_done   (cfg_done),
        .sram       (sram),
        .sram_inv   (sram_inv),
        .out        (out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: shadow word, shift count and active select held as plain integers.
    int m_sh, m_cnt, m_sram;
    bit m_out_reg;

    typedef struct {
        bit en;
        bit head;
        bit commit;
        int exp_sram;
        bit exp_done;
        bit exp_tail;
    } vec_t;

    function automatic bit route(input logic [N_IN-1:0] v, input int s);
        int k;
        k = MAXV - s;
        if (k < N_IN) return v[k];
        return 1'b1;
    endfunction

    function automatic bit exp_out();
`ifdef MUX_OUT_REG_EN
        return m_out_reg;
`else
        return route(in_w, m_sram);
`endif
    endfunction

    function automatic logic [N_IN-1:0] rand_in();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state();
        check("sram", sram, m_sram);
        check("sram_inv", sram_inv, (~m_sram) & MAXV);
        check("cfg_done", cfg_done, m_cnt == SEL_W);
        check("ccff_tail", ccff_tail, (m_sh >> (SEL_W - 1)) & 1);
        check("out", out, exp_out());
    endtask

    task automatic model_reset();
        m_sh = 0; m_cnt = 0; m_sram = 0; m_out_reg = 1'b1;
    endtask

    // Drive at negedge, check the combinational view, clock, update the model and check again.
    task automatic step(input bit en, input bit head, input bit commit, input logic [N_IN-1:0] v);
        @(negedge clk);
        cfg_en = en; ccff_head = head; cfg_commit = commit; in_w = v;
        #1;
        check("out_pre_edge", out, exp_out());
        @(posedge clk);
        m_out_reg = route(in_w, m_sram);
        if (commit && m_cnt == SEL_W) begin
            m_sram = m_sh;
            m_cnt  = en ? 1 : 0;
        end else if (en && m_cnt < SEL_W) begin
            m_cnt++;
        end
        if (en) m_sh = ((m_sh << 1) | int'(head)) & MAXV;
        #1;
        check_state();
    endtask

    // Reset pulse between edges so the asynchronous clear is observed without a clock.
    task automatic pulse_reset();
        @(negedge clk);
        cfg_en = 0; cfg_commit = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_sram", sram, 0);
        check("rst_sram_inv", sram_inv, MAXV);
        check("rst_done", cfg_done, 0);
        check("rst_tail", ccff_tail, 0);
        check("rst_out", out, exp_out());
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tbl[14];
    logic [SEL_W-1:0] tail_seq;
    bit pat[6];

    initial begin
        reset = 1'b1; cfg_en = 0; ccff_head = 0; cfg_commit = 0; in_w = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_sram", sram, 0);
        check("init_sram_inv", sram_inv, MAXV);
        check("init_done", cfg_done, 0);
        check("init_out", out, 1);
        @(negedge clk);
        reset = 1'b0;

        // All-ones load then 1,1,0,1,0,1 load (first bit lands in the MSB).
        tbl[0]  = '{1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 0, 1, 1};
        tbl[6]  = '{0, 0, 1, 63, 0, 1};
        tbl[7]  = '{1, 1, 0, 63, 0, 1};
        tbl[8]  = '{1, 1, 0, 63, 0, 1};
        tbl[9]  = '{1, 0, 0, 63, 0, 1};
        tbl[10] = '{1, 1, 0, 63, 0, 1};
        tbl[11] = '{1, 0, 0, 63, 0, 1};
        tbl[12] = '{1, 1, 0, 63, 1, 1};
        tbl[13] = '{0, 0, 1, 53, 0, 1};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].en, tbl[i].head, tbl[i].commit, rand_in());
            check("tbl_sram", sram, tbl[i].exp_sram);
            check("tbl_done", cfg_done, tbl[i].exp_done);
            check("tbl_tail", ccff_tail, tbl[i].exp_tail);
            if (i == 6) begin
                // sram=63 selects in[0].
                step(0, 0, 0, 46'h1);
                step(0, 0, 0, 46'h1);
                check("sel63_in0_hi", out, 1);
                step(0, 0, 0, ~46'h1);
                step(0, 0, 0, ~46'h1);
                check("sel63_in0_lo", out, 0);
            end
        end

        // sram=53 selects in[10]; verify toggle latency explicitly.
        check("sram53_inv", sram_inv, 10);
        step(0, 0, 0, 46'h0);
        step(0, 0, 0, 46'h0);
        check("in10_lo", out, 0);
        @(negedge clk);
        in_w = 46'h1 << 10;
        #1;
`ifdef MUX_OUT_REG_EN
        check("in10_reg_hold", out, 0);
        @(posedge clk);
        #1;
        check("in10_reg_hi", out, 1);
`else
        check("in10_comb_hi", out, 1);
`endif
        m_out_reg = 1'b1;

        // Early commit after 3 shifts must be ignored.
        pulse_reset();
        step(1, 0, 0, rand_in());
        step(1, 1, 0, rand_in());
        step(1, 0, 0, rand_in());
        step(0, 0, 1, rand_in());
        check("early_commit_sram", sram, 0);
        check("early_commit_done", cfg_done, 0);
        step(1, 1, 0, rand_in());
        step(1, 1, 0, rand_in());
        step(1, 1, 0, rand_in());
        step(0, 0, 1, rand_in());
        check("late_commit_sram", sram, 23);

        // With sram=0 the output is constant 1; tail replays 101100 after 6 shifts.
        pulse_reset();
        pat = '{1, 0, 1, 1, 0, 0};
        tail_seq = '0;
        for (int i = 0; i < 11; i++) begin
            step(1, (i < 6) ? pat[i] : 1'b0, 0, rand_in());
            check("sram0_out_one", out, 1);
            if (i >= 5) tail_seq = {tail_seq[SEL_W-2:0], ccff_tail};
        end
        check("tail_pattern", tail_seq, 6'b101100);

        // Reset after 4 shifts discards progress; commit stays ignored until 6 fresh shifts.
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, rand_in());
        pulse_reset();
        step(1, 1, 0, rand_in());
        for (int i = 0; i < 4; i++) step(1, 0, 0, rand_in());
        step(0, 0, 1, rand_in());
        check("post_rst_commit_ignored", sram, 0);
        step(1, 1, 0, rand_in());
        check("post_rst_done", cfg_done, 1);
        step(1, 0, 1, rand_in());
        check("post_rst_commit_sram", sram, 33);

        // Randomized traffic, including commit with simultaneous shift and occasional reset.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, rand_in());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
